// File: rtl/switch_allocator_rr_if.sv
// Switch-allocator bundle: per-VC requests, routing/flow-control state in,
// per-input VC select and per-output crossbar select out.
interface switch_allocator_rr_if #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2
);
    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic [PORT_NUM-1:0][VC_NUM-1:0]         switch_request_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] out_port_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0] downstream_vc_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0]         on_off_i;
    logic [PORT_NUM-1:0]                     valid_sel_o;
    logic [PORT_NUM-1:0][VW-1:0]             vc_sel_o;
    logic [PORT_NUM-1:0][PW-1:0]             input_sel_o;
    logic [PORT_NUM-1:0]                     out_valid_o;

    modport master (
        output switch_request_i, out_port_i, downstream_vc_i, on_off_i,
        input  valid_sel_o, vc_sel_o, input_sel_o, out_valid_o
    );

    modport slave (
        input  switch_request_i, out_port_i, downstream_vc_i, on_off_i,
        output valid_sel_o, vc_sel_o, input_sel_o, out_valid_o
    );
endinterface

// File: rtl/switch_allocator_rr.sv
// Separable input-first round-robin switch allocator with registered grants.
// Optional macro SA_ISLIP_POINTER_EN: input pointers advance only on a full match.
module switch_allocator_rr #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    switch_allocator_rr_if.slave  sa
);
    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    // Round-robin offsets wrap at the real port/VC count, not the power of two.
    function automatic logic [VW-1:0] vc_wrap(input int base, input int off);
        int s;
        s = base + off;
        if (s >= VC_NUM) s = s - VC_NUM;
        return VW'(s);
    endfunction

    function automatic logic [PW-1:0] port_wrap(input int base, input int off);
        int s;
        s = base + off;
        if (s >= PORT_NUM) s = s - PORT_NUM;
        return PW'(s);
    endfunction

    logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
    logic [PORT_NUM-1:0]             s1_valid;
    logic [PORT_NUM-1:0][VW-1:0]     s1_vc;
    logic [PORT_NUM-1:0][PW-1:0]     s1_port;

    logic [PORT_NUM-1:0][VW-1:0]     in_ptr_d, in_ptr_q;
    logic [PORT_NUM-1:0][PW-1:0]     out_ptr_d, out_ptr_q;
    logic [PORT_NUM-1:0]             valid_sel_d, valid_sel_q;
    logic [PORT_NUM-1:0][VW-1:0]     vc_sel_d, vc_sel_q;
    logic [PORT_NUM-1:0][PW-1:0]     input_sel_d, input_sel_q;
    logic [PORT_NUM-1:0]             out_valid_d, out_valid_q;

    always_comb begin
        logic [PW-1:0] port_c;
        logic [VW-1:0] dvc_c;
        elig   = '0;
        port_c = '0;
        dvc_c  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                port_c = sa.out_port_i[i][v];
                dvc_c  = sa.downstream_vc_i[i][v];
                if (sa.switch_request_i[i][v] && (int'(port_c) < PORT_NUM) &&
                    (int'(dvc_c) < VC_NUM))
                    elig[i][v] = sa.on_off_i[port_c][dvc_c];
            end
        end
    end

    // Stage 1: per-input VC arbitration; descending scan leaves the closest VC at/after the pointer.
    always_comb begin
        logic [VW-1:0] idx_c;
        s1_valid = '0;
        s1_vc    = '0;
        s1_port  = '0;
        idx_c    = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int k = VC_NUM - 1; k >= 0; k--) begin
                idx_c = vc_wrap(int'(in_ptr_q[i]), k);
                if (elig[i][idx_c]) begin
                    s1_valid[i] = 1'b1;
                    s1_vc[i]    = idx_c;
                end
            end
            s1_port[i] = sa.out_port_i[i][s1_vc[i]];
        end
    end

    // Stage 2: per-output input arbitration, then grant fan-back and pointer update.
    always_comb begin
        logic [PW-1:0] in_c;
        out_valid_d = '0;
        input_sel_d = '0;
        valid_sel_d = '0;
        vc_sel_d    = '0;
        out_ptr_d   = out_ptr_q;
        in_ptr_d    = in_ptr_q;
        in_c        = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int k = PORT_NUM - 1; k >= 0; k--) begin
                in_c = port_wrap(int'(out_ptr_q[o]), k);
                if (s1_valid[in_c] && (s1_port[in_c] == PW'(o))) begin
                    out_valid_d[o] = 1'b1;
                    input_sel_d[o] = in_c;
                end
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            if (out_valid_d[o]) begin
                valid_sel_d[input_sel_d[o]] = 1'b1;
                vc_sel_d[input_sel_d[o]]    = s1_vc[input_sel_d[o]];
                out_ptr_d[o]                = port_wrap(int'(input_sel_d[o]), 1);
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
`ifdef SA_ISLIP_POINTER_EN
            if (valid_sel_d[i])
                in_ptr_d[i] = vc_wrap(int'(s1_vc[i]), 1);
`else
            if (s1_valid[i])
                in_ptr_d[i] = vc_wrap(int'(s1_vc[i]), 1);
`endif
        end
    end

    // Output / pointer register boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ptr_q    <= '0;
            out_ptr_q   <= '0;
            valid_sel_q <= '0;
            vc_sel_q    <= '0;
            input_sel_q <= '0;
            out_valid_q <= '0;
        end else begin
            in_ptr_q    <= in_ptr_d;
            out_ptr_q   <= out_ptr_d;
            valid_sel_q <= valid_sel_d;
            vc_sel_q    <= vc_sel_d;
            input_sel_q <= input_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sa.valid_sel_o = valid_sel_q;
    assign sa.vc_sel_o    = vc_sel_q;
    assign sa.input_sel_o = input_sel_q;
    assign sa.out_valid_o = out_valid_q;
endmodule

// File: tb/tb_switch_allocator_rr.sv
// Self-checking bench for switch_allocator_rr: directed scenarios plus random
// traffic against a behavioural matching model.
module tb_switch_allocator_rr;
    localparam int P  = 5;
    localparam int V  = 2;
    localparam int PW = 3;
    localparam int VW = 1;
`ifdef SA_ISLIP_POINTER_EN
    localparam bit ISLIP = 1'b1;
`else
    localparam bit ISLIP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    switch_allocator_rr_if #(.PORT_NUM(P), .VC_NUM(V)) sa_if ();

    switch_allocator_rr #(.PORT_NUM(P), .VC_NUM(V)) dut (
        .clk (clk),
        .rst (rst),
        .sa  (sa_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state and expected registered outputs.
    int                    m_in_ptr  [P];
    int                    m_out_ptr [P];
    logic [P-1:0]          exp_valid_sel;
    logic [P-1:0][VW-1:0]  exp_vc_sel;
    logic [P-1:0][PW-1:0]  exp_input_sel;
    logic [P-1:0]          exp_out_valid;

    function automatic bit eligible(input int i, input int v);
        int p;
        int d;
        p = int'(sa_if.out_port_i[i][v]);
        d = int'(sa_if.downstream_vc_i[i][v]);
        if (!sa_if.switch_request_i[i][v] || p >= P || d >= V) return 1'b0;
        return sa_if.on_off_i[p][d];
    endfunction

    always @(posedge clk) begin
        bit h1 [P];
        int w1 [P];
        int cand;
        bit got;
        exp_valid_sel = '0;
        exp_vc_sel    = '0;
        exp_input_sel = '0;
        exp_out_valid = '0;
        if (rst) begin
            for (int i = 0; i < P; i++) begin
                m_in_ptr[i]  = 0;
                m_out_ptr[i] = 0;
            end
        end else begin
            for (int i = 0; i < P; i++) begin
                h1[i] = 1'b0;
                w1[i] = 0;
                for (int k = 0; k < V; k++) begin
                    if (!h1[i] && eligible(i, (m_in_ptr[i] + k) % V)) begin
                        h1[i] = 1'b1;
                        w1[i] = (m_in_ptr[i] + k) % V;
                    end
                end
            end
            for (int o = 0; o < P; o++) begin
                got = 1'b0;
                for (int k = 0; k < P; k++) begin
                    cand = (m_out_ptr[o] + k) % P;
                    if (!got && h1[cand] && int'(sa_if.out_port_i[cand][w1[cand]]) == o) begin
                        got = 1'b1;
                        exp_out_valid[o]    = 1'b1;
                        exp_input_sel[o]    = PW'(cand);
                        exp_valid_sel[cand] = 1'b1;
                        exp_vc_sel[cand]    = VW'(w1[cand]);
                        m_out_ptr[o]        = (cand + 1) % P;
                    end
                end
            end
            for (int i = 0; i < P; i++) begin
                if (ISLIP ? exp_valid_sel[i] : h1[i])
                    m_in_ptr[i] = (w1[i] + 1) % V;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sa_if.switch_request_i = '0;
        sa_if.out_port_i       = '0;
        sa_if.downstream_vc_i  = '0;
        sa_if.on_off_i         = '1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        sa_if.switch_request_i = '1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (sa_if.valid_sel_o !== '0) begin
                n_fail++;
                $display("FAIL reset_valid_sel cycle %0d: got %h expected 0", c, sa_if.valid_sel_o);
            end
            n_checks++;
            if (sa_if.out_valid_o !== '0) begin
                n_fail++;
                $display("FAIL reset_out_valid cycle %0d: got %h expected 0", c, sa_if.out_valid_o);
            end
        end
        rst = 1'b0;
        n_checks++;
        if (sa_if.valid_sel_o !== '0) begin
            n_fail++;
            $display("FAIL release_valid_sel: got %h expected 0", sa_if.valid_sel_o);
        end
        n_checks++;
        if (sa_if.out_valid_o !== '0) begin
            n_fail++;
            $display("FAIL release_out_valid: got %h expected 0", sa_if.out_valid_o);
        end
        step();
        n_checks++;
        if (sa_if.valid_sel_o !== 5'b00001) begin
            n_fail++;
            $display("FAIL first_grant_valid_sel: got %h expected 01", sa_if.valid_sel_o);
        end
        n_checks++;
        if (sa_if.vc_sel_o !== 5'b00000) begin
            n_fail++;
            $display("FAIL first_grant_vc_sel: got %h expected 0", sa_if.vc_sel_o);
        end
        n_checks++;
        if (sa_if.out_valid_o !== 5'b00001) begin
            n_fail++;
            $display("FAIL first_grant_out_valid: got %h expected 01", sa_if.out_valid_o);
        end
        n_checks++;
        if (sa_if.input_sel_o !== 15'h0000) begin
            n_fail++;
            $display("FAIL first_grant_input_sel: got %h expected 0", sa_if.input_sel_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        sa_if.switch_request_i[2][1] = 1'b1;
        sa_if.out_port_i[2][1]       = 3'd4;
        sa_if.downstream_vc_i[2][1]  = 1'b1;
        step();
        sa_if.switch_request_i[2][1] = 1'b0;
        n_checks++;
        if (sa_if.valid_sel_o !== 5'b00100) begin
            n_fail++;
            $display("FAIL single_valid_sel: got %h expected 04", sa_if.valid_sel_o);
        end
        n_checks++;
        if (sa_if.vc_sel_o !== 5'b00100) begin
            n_fail++;
            $display("FAIL single_vc_sel: got %h expected 04", sa_if.vc_sel_o);
        end
        n_checks++;
        if (sa_if.out_valid_o !== 5'b10000) begin
            n_fail++;
            $display("FAIL single_out_valid: got %h expected 10", sa_if.out_valid_o);
        end
        n_checks++;
        if (sa_if.input_sel_o !== 15'h2000) begin
            n_fail++;
            $display("FAIL single_input_sel: got %h expected 2000", sa_if.input_sel_o);
        end
        step();
        n_checks++;
        if (sa_if.valid_sel_o !== '0) begin
            n_fail++;
            $display("FAIL single_idle_valid_sel: got %h expected 0", sa_if.valid_sel_o);
        end
        n_checks++;
        if (sa_if.out_valid_o !== '0) begin
            n_fail++;
            $display("FAIL single_idle_out_valid: got %h expected 0", sa_if.out_valid_o);
        end
    endtask

    task automatic test_contention();
        int exp_seq [6];
        exp_seq = '{0, 1, 3, 0, 1, 3};
        do_reset();
        sa_if.switch_request_i[0][0] = 1'b1;
        sa_if.switch_request_i[1][0] = 1'b1;
        sa_if.switch_request_i[3][0] = 1'b1;
        sa_if.out_port_i[0][0] = 3'd1;
        sa_if.out_port_i[1][0] = 3'd1;
        sa_if.out_port_i[3][0] = 3'd1;
        step();
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (sa_if.input_sel_o[1] !== PW'(exp_seq[k])) begin
                n_fail++;
                $display("FAIL contention_input_sel grant %0d: got %0d expected %0d", k, sa_if.input_sel_o[1], exp_seq[k]);
            end
            n_checks++;
            if (sa_if.out_valid_o !== 5'b00010) begin
                n_fail++;
                $display("FAIL contention_out_valid grant %0d: got %h expected 02", k, sa_if.out_valid_o);
            end
            step();
        end
    endtask

    task automatic test_vc_rotation();
        do_reset();
        sa_if.switch_request_i[0] = 2'b11;
        sa_if.out_port_i[0][0]    = 3'd2;
        sa_if.out_port_i[0][1]    = 3'd3;
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (sa_if.valid_sel_o[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL vc_rot_valid grant %0d: got %b expected 1", k, sa_if.valid_sel_o[0]);
            end
            n_checks++;
            if (sa_if.vc_sel_o[0] !== VW'(k % 2)) begin
                n_fail++;
                $display("FAIL vc_rot_vc_sel grant %0d: got %0d expected %0d", k, sa_if.vc_sel_o[0], k % 2);
            end
            step();
        end
    endtask

    task automatic test_flow_control();
        do_reset();
        sa_if.on_off_i[2][0]         = 1'b0;
        sa_if.switch_request_i[1][0] = 1'b1;
        sa_if.out_port_i[1][0]       = 3'd2;
        sa_if.downstream_vc_i[1][0]  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (sa_if.valid_sel_o !== '0) begin
                n_fail++;
                $display("FAIL flow_blocked_valid_sel cycle %0d: got %h expected 0", c, sa_if.valid_sel_o);
            end
            n_checks++;
            if (sa_if.out_valid_o !== '0) begin
                n_fail++;
                $display("FAIL flow_blocked_out_valid cycle %0d: got %h expected 0", c, sa_if.out_valid_o);
            end
        end
        sa_if.on_off_i[2][0] = 1'b1;
        step();
        n_checks++;
        if (sa_if.valid_sel_o !== 5'b00010) begin
            n_fail++;
            $display("FAIL flow_open_valid_sel: got %h expected 02", sa_if.valid_sel_o);
        end
        n_checks++;
        if (sa_if.out_valid_o !== 5'b00100) begin
            n_fail++;
            $display("FAIL flow_open_out_valid: got %h expected 04", sa_if.out_valid_o);
        end
        n_checks++;
        if (sa_if.input_sel_o[2] !== 3'd1) begin
            n_fail++;
            $display("FAIL flow_open_input_sel: got %0d expected 1", sa_if.input_sel_o[2]);
        end
    endtask

    task automatic test_pointer_mode();
        logic [VW-1:0] want_vc;
        want_vc = ISLIP ? 1'b0 : 1'b1;
        do_reset();
        sa_if.switch_request_i[0] = 2'b11;
        sa_if.switch_request_i[1] = 2'b11;
        sa_if.out_port_i[0][0] = 3'd3;
        sa_if.out_port_i[0][1] = 3'd3;
        sa_if.out_port_i[1][0] = 3'd3;
        sa_if.out_port_i[1][1] = 3'd3;
        step();
        n_checks++;
        if (sa_if.valid_sel_o !== 5'b00001) begin
            n_fail++;
            $display("FAIL ptr_first_valid_sel: got %h expected 01", sa_if.valid_sel_o);
        end
        n_checks++;
        if (sa_if.out_valid_o !== 5'b01000 || sa_if.input_sel_o[3] !== 3'd0) begin
            n_fail++;
            $display("FAIL ptr_first_out: got valid %h sel %0d expected 08/0", sa_if.out_valid_o, sa_if.input_sel_o[3]);
        end
        step();
        n_checks++;
        if (sa_if.valid_sel_o !== 5'b00010) begin
            n_fail++;
            $display("FAIL ptr_second_valid_sel: got %h expected 02", sa_if.valid_sel_o);
        end
        n_checks++;
        if (sa_if.input_sel_o[3] !== 3'd1) begin
            n_fail++;
            $display("FAIL ptr_second_input_sel: got %0d expected 1", sa_if.input_sel_o[3]);
        end
        n_checks++;
        if (sa_if.vc_sel_o[1] !== want_vc) begin
            n_fail++;
            $display("FAIL ptr_second_vc_sel: got %0d expected %0d", sa_if.vc_sel_o[1], want_vc);
        end
        sa_if.switch_request_i = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            sa_if.switch_request_i = 10'($urandom());
            sa_if.on_off_i         = 10'($urandom() | $urandom());
            for (int i = 0; i < P; i++) begin
                for (int v = 0; v < V; v++) begin
                    sa_if.out_port_i[i][v]      = 3'($urandom_range(0, 6));
                    sa_if.downstream_vc_i[i][v] = 1'($urandom_range(0, 1));
                end
            end
            step();
            n_checks++;
            if (sa_if.valid_sel_o !== exp_valid_sel) begin
                n_fail++;
                $display("FAIL rand_valid_sel cycle %0d: got %h expected %h", c, sa_if.valid_sel_o, exp_valid_sel);
            end
            n_checks++;
            if (sa_if.vc_sel_o !== exp_vc_sel) begin
                n_fail++;
                $display("FAIL rand_vc_sel cycle %0d: got %h expected %h", c, sa_if.vc_sel_o, exp_vc_sel);
            end
            n_checks++;
            if (sa_if.input_sel_o !== exp_input_sel) begin
                n_fail++;
                $display("FAIL rand_input_sel cycle %0d: got %h expected %h", c, sa_if.input_sel_o, exp_input_sel);
            end
            n_checks++;
            if (sa_if.out_valid_o !== exp_out_valid) begin
                n_fail++;
                $display("FAIL rand_out_valid cycle %0d: got %h expected %h", c, sa_if.out_valid_o, exp_out_valid);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_vc_rotation();
        test_flow_control();
        test_pointer_mode();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_allocator_rr.md
Name: switch_allocator_rr

Overview:
- Separable, input-first switch allocator for the router's crossbar.
- Each cycle it matches input-port VCs that hold a switch request to output ports. Stage 1: one round-robin arbiter per input port picks a VC. Stage 2: one round-robin arbiter per output port picks an input.
- Drives the input ports' VC select and valid select, and the crossbar's per-output input select.
- Gated by downstream on/off flow control.

Parameters:
- PORT_NUM, 5, number of input and output ports.
- VC_NUM, 2, virtual channels per port (VC_NUM >= 1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- switch_request_i  input  [PORT_NUM][VC_NUM]  VC holds a flit ready for switch traversal.
- out_port_i  input  [PORT_NUM][VC_NUM] x port_t  output port computed for each input VC.
- downstream_vc_i  input  [PORT_NUM][VC_NUM] x $clog2(VC_NUM)  downstream VC allocated to each input VC.
- on_off_i  input  [PORT_NUM][VC_NUM]  per output port and downstream VC; 1 = downstream can accept a flit.
- valid_sel_o  output  [PORT_NUM]  input port granted this cycle.
- vc_sel_o  output  [PORT_NUM] x $clog2(VC_NUM)  granted VC index per input port.
- input_sel_o  output  [PORT_NUM] x $clog2(PORT_NUM)  per output port, index of the granted input port (crossbar select).
- out_valid_o  output  [PORT_NUM]  per output port, a flit traverses this cycle.

Behaviour:
- Eligibility: VC v of input i is eligible iff all of the following hold:
  - switch_request_i[i][v]
  - on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]] is 1
  - out_port_i[i][v] < PORT_NUM
  Out-of-range port codes are never eligible.
- Stage 1 (per input i): round-robin over eligible VCs, starting at in_ptr[i]; the winner is the first eligible VC at or after the pointer, with wrap-around. No eligible VC means no stage-1 request from input i.
- Stage 2 (per output o): candidates are the inputs whose stage-1 winner targets o. Round-robin starting at out_ptr[o]; the first candidate at or after the pointer wins, with wrap-around.
- Both stages are combinational on the current inputs. All outputs are registered, so a grant appears exactly 1 cycle after the sampled request.
- Registered outputs:
  - valid_sel_o[i]=1 and vc_sel_o[i]=winning VC iff input i won some output.
  - out_valid_o[o]=1 and input_sel_o[o]=winning input iff output o granted.
  - Non-granted vc_sel_o/input_sel_o fields are 0.
- Matching guarantees: at most one grant per input port and per output port each cycle; every output grant corresponds to exactly one input grant.
- Pointer update (on the clock edge, computed from the same sampled inputs as the grant):
  - out_ptr[o] <= (granted input + 1) mod PORT_NUM, only when output o grants.
  - in_ptr[i]: see Optional Feature.
  - Pointers with no grant hold their value.
- Requesters hold switch_request_i asserted until they see valid_sel_o. A requester whose flit was the last one deasserts in the cycle the grant is visible. The allocator re-evaluates every cycle and does not store requests.
- on_off_i dropping in the same cycle as a request blocks that request in that cycle. A registered grant already issued is not revoked.
- Reset:
  - All outputs 0.
  - All in_ptr and out_ptr are 0, so index 0 has highest priority.
  - First possible grant is in the cycle after rst deasserts and a request is sampled.
  - rst asserted mid-operation clears outputs and pointers at the next edge, regardless of pending requests.
- Widths: the mod arithmetic wraps at PORT_NUM/VC_NUM, not at the power of two. When VC_NUM=1, vc_sel_o and in_ptr are a constant 0, with a width of 1 bit.

Optional Feature:
- Macro: SA_ISLIP_POINTER_EN.
- Defined: in_ptr[i] <= (stage-1 winner + 1) mod VC_NUM only when input i also wins in stage 2. This is iSLIP-style and desynchronises the pointers.
- Undefined: in_ptr[i] advances to (stage-1 winner + 1) mod VC_NUM whenever input i has a stage-1 winner, whether or not stage 2 grants it.
- Grant logic and outputs are otherwise identical.

Test Plan:
- Reset: hold rst 3 cycles with all requests high -> all outputs 0 during reset and in the first cycle after release. Cycle 2 after release: input 0 VC 0 granted first.
- Single requester: input 2 VC 1 -> out_port 4, on_off_i[4][dvc]=1 -> next cycle valid_sel_o[2]=1, vc_sel_o[2]=1, out_valid_o[4]=1, input_sel_o[4]=2. All other outputs 0.
- Output contention: inputs 0, 1 and 3 all request output 1 continuously -> grants to output 1 rotate 0,1,3,0,1,3; exactly one out_valid_o per cycle.
- VC rotation: input 0 both VCs request distinct outputs continuously with no contention -> vc_sel_o[0] alternates 0,1,0,1.
- Flow control: on_off_i[2][0]=0 with input 1 VC 0 requesting port 2, downstream VC 0 -> no grant. Raise on_off_i -> grant on the next cycle.
- Feature check: inputs 0 and 1 both have VC 0 -> out 3 and VC 1 -> out 3; input 1 loses stage 2.
  - With SA_ISLIP_POINTER_EN: in_ptr[1] is unchanged, and input 1 VC 0 is granted when it next wins output 3.
  - Without it: in_ptr[1] advances, and input 1 VC 1 is granted instead.
